// File: rtl/rhd_emu_pkg.sv
// Shared definitions for the multi-port RHD2000 headstage emulator.
// Holds the 16-bit word type, command opcodes, the read-only "INTAN"
// register window, the LFSR polynomial and the helpers that build
// per-stream seeds and step the LFSR.
package rhd_emu_pkg;

  typedef logic [15:0] word_t;

  // Command opcodes, taken from cmd[15:14]
  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_CALIB   = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  // Read-only company-ID window at registers 40..44
  localparam logic [5:0] ROM_ADDR_FIRST = 6'd40;
  localparam logic [5:0] ROM_ADDR_LAST  = 6'd44;
  localparam logic [7:0] ROM_I = 8'h49;
  localparam logic [7:0] ROM_N = 8'h4E;
  localparam logic [7:0] ROM_T = 8'h54;
  localparam logic [7:0] ROM_A = 8'h41;

  // Galois LFSR polynomial and the seed used when a computed seed is zero
  localparam word_t LFSR_TAPS        = 16'hB400;
  localparam word_t LFSR_LOCKUP_SEED = 16'hACE1;

  function automatic logic is_rom_addr(input logic [5:0] addr);
    return (addr >= ROM_ADDR_FIRST) && (addr <= ROM_ADDR_LAST);
  endfunction

  function automatic logic [7:0] rom_value(input logic [5:0] addr);
    logic [7:0] v;
    case (addr)
      6'd40:   v = ROM_I;
      6'd41:   v = ROM_N;
      6'd42:   v = ROM_T;
      6'd43:   v = ROM_A;
      6'd44:   v = ROM_N;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic word_t lfsr_next(input word_t s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Seed for port/line; an all-zero seed would lock the LFSR, so swap it out
  function automatic word_t lfsr_seed(input int base, input int port, input int line);
    word_t s;
    s = word_t'(base + 2 * port + line);
    if (s == 16'h0000) s = LFSR_LOCKUP_SEED;
    return s;
  endfunction

endpackage

// File: rtl/rhd_emu_lfsr.sv
// 16-bit Galois LFSR used as the CONVERT data source of one MISO line.
// Ports: clk, rst (sync, active-high, reloads SEED), step (advance one
// state this cycle), value (current state).
module rhd_emu_lfsr
  import rhd_emu_pkg::*;
#(
  parameter word_t SEED = LFSR_LOCKUP_SEED
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  step,
  output word_t value
);

  word_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign value = state_q;

endmodule

// File: rtl/rhd_headstage_emu_multi.sv
// Multi-port RHD2000 headstage emulator. A shared MOSI/CS/SCLK bus is
// synchronised into clk, framed by a small FSM and decoded once per valid
// 16-bit frame. Every port owns two response pipelines (MISO1/MISO2); a
// command's result is shifted out two frames after it was received.
// Ports: clk, rst (sync, active-high), MOSI/CS/SCLK (async SPI inputs),
// MISO1/MISO2 (one bit per emulated port, optionally delayed).
module rhd_headstage_emu_multi
  import rhd_emu_pkg::*;
#(
  parameter int NUM_PORTS  = 8,
  parameter int SEED_BASE  = 0,
  parameter int DATA_MODE  = 0,
  parameter int MISO_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MOSI,
  input  logic                 CS,
  input  logic                 SCLK,
  output logic [NUM_PORTS-1:0] MISO1,
  output logic [NUM_PORTS-1:0] MISO2
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  // {mosi, cs, sclk}; all reset to 0 so that a CS held low through reset
  // does not look like a fresh CS fall afterwards.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, last_q, last_d;
  logic [1:0] state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  word_t      cmd_q, cmd_d;
  logic [7:0] regfile_q [64];
  logic [7:0] regfile_d [64];
  logic [7:0] rd_data_q, rd_data_d;

  logic mosi_s, cs_s, sclk_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic frame_start, shift_fire, decode_fire, lfsr_step, in_shift;
  logic [1:0] opcode;
  logic [5:0] addr;
  logic [7:0] wdata;
  word_t      common_result;
  logic [NUM_PORTS-1:0] miso1_raw, miso2_raw;

  assign mosi_s    = sync2_q[2];
  assign cs_s      = sync2_q[1];
  assign sclk_s    = sync2_q[0];
  assign cs_fall   = last_q[1] & ~cs_s;
  assign cs_rise   = ~last_q[1] & cs_s;
  assign sclk_rise = ~last_q[0] & sclk_s;
  assign sclk_fall = last_q[0] & ~sclk_s;

  assign opcode = cmd_q[15:14];
  assign addr   = cmd_q[13:8];
  assign wdata  = cmd_q[7:0];

  assign in_shift    = (state_q == ST_SHIFT);
  assign frame_start = (state_q == ST_IDLE) & cs_fall;
  // CS rise wins over a coincident SCLK edge; after the 16th fall the
  // shifters stop so the LSB is held until CS rises.
  assign shift_fire  = in_shift & ~cs_rise & sclk_fall & (bit_cnt_q < 5'd16);
  assign decode_fire = (state_q == ST_DECODE);
  assign lfsr_step   = decode_fire & (opcode == OP_CONVERT);

  always_comb begin
    sync1_d     = {MOSI, CS, SCLK};
    sync2_d     = sync1_q;
    last_d      = sync2_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    cmd_d       = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 5'd0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = (bit_cnt_q == 5'd16) ? ST_DECODE : ST_IDLE;
        end else if (sclk_rise) begin
          cmd_d = {cmd_q[14:0], mosi_s};
          if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_DECODE: begin
        state_d     = ST_IDLE;
        frame_cnt_d = frame_cnt_q + 5'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file: contents are identical for every port because MOSI is
  // shared, so one copy serves all of them. The read port is registered;
  // the address is stable from the 16th SCLK rise until DECODE.
  always_comb begin
    regfile_d = regfile_q;
    rd_data_d = regfile_q[addr];
    if (decode_fire && (opcode == OP_WRITE) && !is_rom_addr(addr))
      regfile_d[addr] = wdata;
  end

  always_comb begin
    case (opcode)
      OP_WRITE: common_result = {8'hFF, wdata};
      OP_READ:  common_result = {8'h00, is_rom_addr(addr) ? rom_value(addr) : rd_data_q};
      default:  common_result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      last_q      <= 3'b000;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      frame_cnt_q <= 5'd0;
      cmd_q       <= 16'h0000;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < 64; i++) regfile_q[i] <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      last_q      <= last_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cmd_q       <= cmd_d;
      rd_data_q   <= rd_data_d;
      regfile_q   <= regfile_d;
    end
  end

  // Per-port datapath: two LFSRs, two output shifters, two-deep pipeline.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    word_t lfsr_val [2];
    word_t conv_result [2];
    word_t shift_q [2];
    word_t shift_d [2];
    word_t pipe0_q [2];
    word_t pipe0_d [2];
    word_t pipe1_q [2];
    word_t pipe1_d [2];

    rhd_emu_lfsr #(.SEED(lfsr_seed(SEED_BASE, gi, 0))) u_lfsr_miso1 (
      .clk   (clk),
      .rst   (rst),
      .step  (lfsr_step),
      .value (lfsr_val[0])
    );

    rhd_emu_lfsr #(.SEED(lfsr_seed(SEED_BASE, gi, 1))) u_lfsr_miso2 (
      .clk   (clk),
      .rst   (rst),
      .step  (lfsr_step),
      .value (lfsr_val[1])
    );

    always_comb begin
      for (int m = 0; m < 2; m++) begin
        if (opcode != OP_CONVERT)
          conv_result[m] = common_result;
        else if (DATA_MODE == 1)
          conv_result[m] = {addr, 4'(gi), 1'(m), frame_cnt_q};
        else
          conv_result[m] = lfsr_val[m];
        shift_d[m] = shift_q[m];
        pipe0_d[m] = pipe0_q[m];
        pipe1_d[m] = pipe1_q[m];
        if (frame_start)
          shift_d[m] = pipe1_q[m];
        else if (shift_fire)
          shift_d[m] = {shift_q[m][14:0], 1'b0};
        if (decode_fire) begin
          pipe1_d[m] = pipe0_q[m];
          pipe0_d[m] = conv_result[m];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          shift_q[m] <= 16'h0000;
          pipe0_q[m] <= 16'h0000;
          pipe1_q[m] <= 16'h0000;
        end else begin
          shift_q[m] <= shift_d[m];
          pipe0_q[m] <= pipe0_d[m];
          pipe1_q[m] <= pipe1_d[m];
        end
      end
    end

    // Outputs drop to 0 as soon as the FSM leaves SHIFT (CS rise detect)
    assign miso1_raw[gi] = in_shift & shift_q[0][15];
    assign miso2_raw[gi] = in_shift & shift_q[1][15];
  end

  // Optional cable-delay emulation
  if (MISO_DELAY == 0) begin : g_no_delay
    assign MISO1 = miso1_raw;
    assign MISO2 = miso2_raw;
  end else begin : g_delay
    logic [NUM_PORTS-1:0] dly1_q [MISO_DELAY];
    logic [NUM_PORTS-1:0] dly1_d [MISO_DELAY];
    logic [NUM_PORTS-1:0] dly2_q [MISO_DELAY];
    logic [NUM_PORTS-1:0] dly2_d [MISO_DELAY];

    always_comb begin
      dly1_d[0] = miso1_raw;
      dly2_d[0] = miso2_raw;
      for (int i = 1; i < MISO_DELAY; i++) begin
        dly1_d[i] = dly1_q[i-1];
        dly2_d[i] = dly2_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < MISO_DELAY; i++) begin
        if (rst) begin
          dly1_q[i] <= '0;
          dly2_q[i] <= '0;
        end else begin
          dly1_q[i] <= dly1_d[i];
          dly2_q[i] <= dly2_d[i];
        end
      end
    end

    assign MISO1 = dly1_q[MISO_DELAY-1];
    assign MISO2 = dly2_q[MISO_DELAY-1];
  end

endmodule

// File: tb/tb_rhd_headstage_emu_multi.sv
// Self-checking bench for rhd_headstage_emu_multi. Three instances share
// the SPI bus: A (8 ports, LFSR data), B (4 ports, ramp data) and
// C (2 ports, seed base 100, 5-cycle MISO delay, separate reset).
module tb_rhd_headstage_emu_multi;

  localparam int HALF = 10;  // clk cycles per SCLK half period

  logic clk;
  logic rst_ab, rst_c;
  logic mosi, cs, sclk;
  logic [7:0] miso1_a, miso2_a;
  logic [3:0] miso1_b, miso2_b;
  logic [1:0] miso1_c, miso2_c;

  logic [15:0] rx_a [8][2];
  logic [15:0] rx_b [4][2];
  logic [15:0] rx_c [2][2];
  logic [15:0] ms_a [8][2];
  logic [15:0] ms_c [2][2];

  int n_compared   = 0;
  int n_mismatched = 0;
  int txn          = 0;

  rhd_headstage_emu_multi #(.NUM_PORTS(8)) u_dut_a (
    .clk(clk), .rst(rst_ab), .MOSI(mosi), .CS(cs), .SCLK(sclk),
    .MISO1(miso1_a), .MISO2(miso2_a)
  );

  rhd_headstage_emu_multi #(.NUM_PORTS(4), .DATA_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst_ab), .MOSI(mosi), .CS(cs), .SCLK(sclk),
    .MISO1(miso1_b), .MISO2(miso2_b)
  );

  rhd_headstage_emu_multi #(.NUM_PORTS(2), .SEED_BASE(100), .MISO_DELAY(5)) u_dut_c (
    .clk(clk), .rst(rst_c), .MOSI(mosi), .CS(cs), .SCLK(sclk),
    .MISO1(miso1_c), .MISO2(miso2_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] ref_seed(input int base, input int p, input int m);
    logic [15:0] s;
    s = 16'(base + 2 * p + m);
    return (s == 16'h0000) ? 16'hACE1 : s;
  endfunction

  task automatic capture_bit(input int i);
    for (int p = 0; p < 8; p++) begin
      rx_a[p][0][15-i] = miso1_a[p];
      rx_a[p][1][15-i] = miso2_a[p];
    end
    for (int p = 0; p < 4; p++) begin
      rx_b[p][0][15-i] = miso1_b[p];
      rx_b[p][1][15-i] = miso2_b[p];
    end
    for (int p = 0; p < 2; p++) begin
      rx_c[p][0][15-i] = miso1_c[p];
      rx_c[p][1][15-i] = miso2_c[p];
    end
  endtask

  // One SPI transaction; MISO is sampled just before each SCLK rise
  task automatic spi_frame(input logic [15:0] cmd, input int nbits);
    for (int p = 0; p < 8; p++) begin rx_a[p][0] = '0; rx_a[p][1] = '0; end
    for (int p = 0; p < 4; p++) begin rx_b[p][0] = '0; rx_b[p][1] = '0; end
    for (int p = 0; p < 2; p++) begin rx_c[p][0] = '0; rx_c[p][1] = '0; end
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[15-i];
      repeat (HALF) @(negedge clk);
      capture_bit(i);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    $display("txn %0d cmd=0x%04h bits=%0d a.miso1[0]=0x%04h b.miso2[2]=0x%04h c.miso1[0]=0x%04h",
             txn, cmd, nbits, rx_a[0][0], rx_b[2][1], rx_c[0][0]);
    txn++;
  endtask

  task automatic check_common(input string tag, input logic [15:0] exp);
    for (int p = 0; p < 8; p++)
      for (int m = 0; m < 2; m++)
        check_val($sformatf("%s_a_p%0d_m%0d", tag, p, m), rx_a[p][m], exp);
    for (int p = 0; p < 4; p++)
      for (int m = 0; m < 2; m++)
        check_val($sformatf("%s_b_p%0d_m%0d", tag, p, m), rx_b[p][m], exp);
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 2; m++)
        check_val($sformatf("%s_c_p%0d_m%0d", tag, p, m), rx_c[p][m], exp);
  endtask

  // Compare LFSR streams of A and C with the model, then advance the model
  task automatic check_lfsr(input string tag);
    for (int p = 0; p < 8; p++)
      for (int m = 0; m < 2; m++) begin
        check_val($sformatf("%s_a_p%0d_m%0d", tag, p, m), rx_a[p][m], ms_a[p][m]);
        ms_a[p][m] = ref_step(ms_a[p][m]);
      end
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 2; m++) begin
        check_val($sformatf("%s_c_p%0d_m%0d", tag, p, m), rx_c[p][m], ms_c[p][m]);
        ms_c[p][m] = ref_step(ms_c[p][m]);
      end
  endtask

  task automatic check_ramp(input string tag, input int ch, input int fcnt);
    logic [15:0] exp;
    for (int p = 0; p < 4; p++)
      for (int m = 0; m < 2; m++) begin
        exp = {6'(ch), 4'(p), 1'(m), 5'(fcnt)};
        check_val($sformatf("%s_b_p%0d_m%0d", tag, p, m), rx_b[p][m], exp);
      end
  endtask

  initial begin
    int lat_a, lat_c, dup_pairs;
    logic [1:0] nz;
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rst_ab = 1'b1; rst_c = 1'b1;
    for (int p = 0; p < 8; p++)
      for (int m = 0; m < 2; m++) ms_a[p][m] = ref_seed(0, p, m);
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 2; m++) ms_c[p][m] = ref_seed(100, p, m);
    repeat (5) @(negedge clk);
    rst_ab = 1'b0; rst_c = 1'b0;
    repeat (5) @(negedge clk);

    check_val("reset_a", {miso1_a, miso2_a}, 16'h0000);
    check_val("reset_b", {miso1_b, miso2_b}, 8'h00);
    check_val("reset_c", {miso1_c, miso2_c}, 4'h0);

    spi_frame(16'h0700, 16); check_common("f0_reset_pipe", 16'h0000);  // CONVERT ch7
    spi_frame(16'hE800, 16); check_common("f1_reset_pipe", 16'h0000);  // READ 40
    spi_frame(16'hE900, 16);                                           // READ 41
    check_lfsr("f2_conv");
    check_ramp("f2_ramp", 7, 0);
    check_val("ramp_p2_miso2", rx_b[2][1], 16'h1CA0);
    spi_frame(16'h85A3, 16); check_common("rom40", 16'h0049);          // WRITE 5 <- A3
    spi_frame(16'hC500, 16); check_common("rom41", 16'h004E);          // READ 5
    spi_frame(16'hA855, 16); check_common("wr5", 16'hFFA3);            // WRITE 40 (ROM)
    spi_frame(16'hE800, 16); check_common("rd5", 16'h00A3);            // READ 40
    spi_frame(16'h5500, 16); check_common("wr_rom_echo", 16'hFF55);    // CALIBRATE
    spi_frame(16'h8677, 9);                                            // short WRITE 6
    spi_frame(16'hC600, 16); check_common("short_keep", 16'h0049);     // READ 6
    spi_frame(16'h5500, 16); check_common("calib_zero", 16'h0000);
    spi_frame(16'h5500, 16); check_common("rd6_untouched", 16'h0000);
    spi_frame(16'h0300, 16); check_common("calib_zero2", 16'h0000);    // CONVERT ch3
    spi_frame(16'h5500, 16); check_common("calib_zero3", 16'h0000);
    spi_frame(16'h5500, 16);
    check_lfsr("f14_conv");
    check_ramp("f14_ramp", 3, 11);

    // 100 CONVERTs plus two flush frames
    for (int j = 0; j < 102; j++) begin
      spi_frame((j < 100) ? {2'b00, 6'(j), 8'h00} : 16'h5500, 16);
      if (j >= 2) check_lfsr($sformatf("conv%0d", j - 2));
      if (j == 2) begin
        dup_pairs = 0;
        for (int s = 0; s < 16; s++)
          for (int t = s + 1; t < 16; t++)
            if (rx_a[s/2][s%2] == rx_a[t/2][t%2]) dup_pairs++;
        check_val("stream_dup_pairs", dup_pairs, 0);
      end
    end

    // Latency and mid-frame reset
    spi_frame(16'h895A, 16);                                           // WRITE 9 <- 5A
    spi_frame(16'h5500, 16);
    @(negedge clk);
    cs = 1'b0;
    lat_a = -1; lat_c = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (lat_a < 0 && miso1_a[0]) lat_a = n;
      if (lat_c < 0 && miso1_c[0]) lat_c = n;
    end
    check_val("lat_a", lat_a, 3);
    check_val("lat_c", lat_c, 8);
    check_val("lat_lag", lat_c - lat_a, 5);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    check_val("pre_rst_c", miso1_c[0], 1'b1);
    rst_c = 1'b1;
    @(negedge clk);
    check_val("rst_zero_c", {miso1_c, miso2_c}, 4'h0);
    @(negedge clk);
    rst_c = 1'b0;
    nz = 2'b00;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      repeat (HALF) begin @(negedge clk); nz = nz | miso1_c | miso2_c; end
      sclk = 1'b0;
      repeat (HALF) begin @(negedge clk); nz = nz | miso1_c | miso2_c; end
    end
    check_val("post_rst_quiet_c", nz, 2'b00);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_frame(16'h5500, 16);
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 2; m++)
        check_val($sformatf("after_rst_c_p%0d_m%0d", p, m), rx_c[p][m], 16'h0000);
    check_val("short2_keep_a", rx_a[3][1], 16'hFF5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
